// File: rtl/frame_buf.sv
// Double-buffered 64x32 RGB444 frame store: back bank filled over valid/ready,
// front bank read by the display controller; swap only at a frame boundary.
// Ports: clk, rst (sync, high); wr_valid/wr_ready/wr_x/wr_y/wr_data/wr_last
// write port; r_addr/row_sel from controller; din_top/din_btm registered
// read data; front_sel displayed bank; swap_pending full frame awaiting swap.
module frame_buf #(
  parameter int COLS      = 64,
  parameter int HALF_ROWS = 16,
  parameter int DATA_W    = 12,
  parameter int ADDR_W    = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [5:0]        wr_x,
  input  logic [4:0]        wr_y,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_last,
  input  logic [ADDR_W-1:0] r_addr,
  input  logic [3:0]        row_sel,
  output logic [DATA_W-1:0] din_top,
  output logic [DATA_W-1:0] din_btm,
  output logic              front_sel,
  output logic              swap_pending
);

  localparam int DEPTH = COLS * HALF_ROWS;

  typedef enum logic [1:0] {
    ST_CLEAR,
    ST_FILL,
    ST_PEND
  } state_t;

  state_t            state;
  state_t            state_nx;
  logic [ADDR_W-1:0] clr_addr;
  logic [3:0]        prev_row;
  logic              boundary;
  logic              swap;
  logic              clearing;
  logic              wr_fire;

  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] wdata;
  logic [3:0]        we;
  logic [DATA_W-1:0] rq [4];

  // Output zeroing and bank select are delayed to line up with the RAM
  // read register.
  logic              zero_q;
  logic              sel_q;

  assign boundary = (prev_row == 4'd15) && (row_sel == 4'd0);
  assign clearing = (state == ST_CLEAR);
  assign wr_fire  = wr_valid && wr_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_CLEAR;
      clr_addr  <= '0;
      prev_row  <= '0;
      front_sel <= 1'b0;
    end else begin
      state    <= state_nx;
      prev_row <= row_sel;
      if (clearing && (clr_addr != '1))
        clr_addr <= clr_addr + 1'b1;
      if (swap)
        front_sel <= ~front_sel;
    end
  end

  always_comb begin
    state_nx = state;
    swap     = 1'b0;
    wr_ready = 1'b0;
    unique case (state)
      ST_CLEAR: begin
        if (clr_addr == '1)
          state_nx = ST_FILL;
      end
      ST_FILL: begin
        wr_ready = 1'b1;
        if (wr_valid && wr_last)
          state_nx = ST_PEND;
      end
      ST_PEND: begin
        if (boundary) begin
          swap     = 1'b1;
          state_nx = ST_FILL;
        end
      end
      default: state_nx = ST_CLEAR;
    endcase
  end

  assign swap_pending = (state == ST_PEND);

  assign waddr = clearing ? clr_addr : {wr_y[3:0], wr_x};
  assign wdata = clearing ? '0 : wr_data;

  // RAM index is {bank, half}; clearing hits all four at once.
  always_comb begin
    we = '0;
    for (int i = 0; i < 4; i++) begin
      if (clearing)
        we[i] = 1'b1;
      else if (wr_fire
               && (i[1] == ~front_sel)
               && (i[0] == wr_y[4]))
        we[i] = 1'b1;
    end
  end

  for (genvar g = 0; g < 4; g++) begin : g_ram
    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
      if (we[g])
        mem[waddr] <= wdata;
      rq[g] <= mem[r_addr];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      zero_q <= 1'b1;
      sel_q  <= 1'b0;
    end else begin
      zero_q <= clearing;
      sel_q  <= front_sel;
    end
  end

  always_comb begin
    din_top = '0;
    din_btm = '0;
    if (!zero_q) begin
      din_top = sel_q ? rq[2] : rq[0];
      din_btm = sel_q ? rq[3] : rq[1];
    end
  end

endmodule

// File: tb/tb_frame_buf.sv
// Scoreboard bench for frame_buf: a frame-level model predicts read data and
// handshake/bank status; a monitor compares din one cycle after each read.
module tb_frame_buf;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr_valid = 1'b0;
  logic        wr_ready;
  logic [5:0]  wr_x = '0;
  logic [4:0]  wr_y = '0;
  logic [11:0] wr_data = '0;
  logic        wr_last = 1'b0;
  logic [9:0]  r_addr = '0;
  logic [3:0]  row_sel = '0;
  logic [11:0] din_top;
  logic [11:0] din_btm;
  logic        front_sel;
  logic        swap_pending;

  frame_buf dut (
    .clk          (clk),
    .rst          (rst),
    .wr_valid     (wr_valid),
    .wr_ready     (wr_ready),
    .wr_x         (wr_x),
    .wr_y         (wr_y),
    .wr_data      (wr_data),
    .wr_last      (wr_last),
    .r_addr       (r_addr),
    .row_sel      (row_sel),
    .din_top      (din_top),
    .din_btm      (din_btm),
    .front_sel    (front_sel),
    .swap_pending (swap_pending)
  );

  always #5 clk = ~clk;

  // Reference model: pixel arrays per bank/half plus frame bookkeeping.
  logic [11:0] mem [2][2][1024];
  bit          m_front;
  bit          m_pend;
  int          m_clr_left;
  logic [3:0]  m_prev;
  bit          checking = 0;

  typedef struct {
    logic [11:0] t;
    logic [11:0] b;
  } rd_t;
  rd_t exp_q[$];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin : monitor
    rd_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("din_top", din_top, e.t);
      chk("din_btm", din_btm, e.b);
    end
  end

  task automatic tick();
    rd_t e;
    @(negedge clk);
    if (checking) begin
      chk("wr_ready", wr_ready, (m_clr_left == 0 && !m_pend));
      chk("front_sel", front_sel, m_front);
      chk("swap_pending", swap_pending, m_pend);
      if (rst || m_clr_left > 0) begin
        e.t = '0;
        e.b = '0;
      end else begin
        e.t = mem[m_front][0][r_addr];
        e.b = mem[m_front][1][r_addr];
      end
      exp_q.push_back(e);
    end
    if (rst) begin
      m_clr_left = 1024;
      m_front    = 0;
      m_pend     = 0;
      for (int b = 0; b < 2; b++)
        for (int h = 0; h < 2; h++)
          for (int a = 0; a < 1024; a++)
            mem[b][h][a] = '0;
    end else if (m_clr_left > 0) begin
      m_clr_left--;
    end else if (m_pend) begin
      if (m_prev == 4'd15 && row_sel == 4'd0) begin
        m_front = !m_front;
        m_pend  = 0;
      end
    end else if (wr_valid) begin
      mem[!m_front][wr_y[4]][wr_y[3:0] * 64 + wr_x] = wr_data;
      if (wr_last)
        m_pend = 1;
    end
    m_prev = rst ? 4'd0 : row_sel;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    checking = 1;
    tick();
    rst = 1'b0;
  endtask

  task automatic run_clear();
    int n = 0;
    while (wr_ready !== 1'b1 && n < 1100) begin
      wr_valid = 1'($urandom);
      wr_last  = 1'($urandom);
      wr_x     = 6'($urandom);
      wr_y     = 5'($urandom);
      wr_data  = 12'($urandom);
      r_addr   = 10'($urandom);
      row_sel  = 4'($urandom);
      tick();
      n++;
    end
    chk("clear_cycles", n, 1024);
    wr_valid = 1'b0;
    wr_last  = 1'b0;
    row_sel  = 4'd3;
  endtask

  task automatic wpix(int x, int y, int d, bit last);
    wr_valid = 1'b1;
    wr_x     = 6'(x);
    wr_y     = 5'(y);
    wr_data  = 12'(d);
    wr_last  = last;
    tick();
    wr_valid = 1'b0;
    wr_last  = 1'b0;
  endtask

  task automatic boundary();
    row_sel = 4'd15;
    tick();
    row_sel = 4'd0;
    tick();
    row_sel = 4'd3;
    tick();
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    do_reset();
    run_clear();
    repeat (6) tick();

    // Two pixels, one per half, then swap and read them back.
    wpix(5, 3, 12'hA5C, 0);
    r_addr = 10'd0;
    tick();
    r_addr = 10'd511;
    tick();
    r_addr = 10'd1023;
    tick();
    wpix(5, 19, 12'h3F1, 1);
    boundary();
    chk("front_after_swap", front_sel, 1);
    r_addr = 10'd197;
    tick();
    tick();

    // Pending frame must ignore writes until the boundary.
    wpix(1, 1, 12'h123, 1);
    row_sel = 4'd7;
    for (int i = 0; i < 50; i++) begin
      wr_valid = 1'b1;
      wr_data  = 12'hFFF;
      wr_x     = 6'($urandom);
      wr_y     = 5'($urandom);
      wr_last  = 1'($urandom);
      tick();
    end
    wr_valid = 1'b0;
    wr_last  = 1'b0;
    boundary();
    r_addr = 10'd65;
    tick();
    repeat (20) begin
      r_addr = 10'($urandom);
      tick();
    end

    // wr_last coincident with a boundary: swap waits for the next one.
    row_sel = 4'd15;
    tick();
    row_sel = 4'd0;
    wpix(9, 20, 12'h5A5, 1);
    row_sel = 4'd3;
    repeat (3) tick();
    boundary();
    r_addr = 10'd265;
    tick();

    // Reset during a pending swap with bank 1 displayed.
    wpix(0, 0, 12'hABC, 1);
    tick();
    do_reset();
    chk("front_after_rst", front_sel, 0);
    chk("pend_after_rst", swap_pending, 0);
    run_clear();

    // Ramp frame, swap, full-address sweep.
    for (int y = 0; y < 32; y++)
      for (int x = 0; x < 64; x++)
        wpix(x, y, (y * 64 + x) ^ 12'h800, (y == 31 && x == 63));
    boundary();
    for (int a = 0; a < 1024; a++) begin
      r_addr = 10'(a);
      tick();
    end

    // Random traffic with a slowly advancing row counter.
    for (int i = 0; i < 3000; i++) begin
      wr_valid = 1'($urandom);
      wr_x     = 6'($urandom);
      wr_y     = 5'($urandom);
      wr_data  = 12'($urandom);
      wr_last  = ($urandom_range(0, 99) == 0);
      r_addr   = 10'($urandom);
      if ($urandom_range(0, 2) == 0)
        row_sel = row_sel + 4'd1;
      tick();
    end
    wr_valid = 1'b0;
    tick();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
